// File: rtl/mdu_sched_if.sv
// mdu_sched_if: E-stage multiply/divide request bus with HI/LO and stall return signals
interface mdu_sched_if;
  logic        Start;
  logic [2:0]  MDU_Sel;
  logic [31:0] A;
  logic [31:0] B;
  logic        IsMD_D;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic        Stall_MD;
  logic [31:0] HI;
  logic [31:0] LO;
  modport master (
    output Start, MDU_Sel, A, B, IsMD_D, Flush,
    input  Busy, Done, Stall_MD, HI, LO
  );
  modport slave (
    input  Start, MDU_Sel, A, B, IsMD_D, Flush,
    output Busy, Done, Stall_MD, HI, LO
  );
endinterface

// File: rtl/mdu_sched.sv
// mdu_sched: fixed-latency mult/div scheduler owning HI/LO and the D-stage MDU stall
module mdu_sched #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input logic         Clk,
  input logic         Rst,
  mdu_sched_if.slave  bus
);
  localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t      r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [31:0] r_hi, r_lo, r_hi_p, r_lo_p;
  logic [31:0] w_hi_n, w_lo_n, w_hi_p_n, w_lo_p_n;
  logic        w_busy, w_acc, w_md, w_div, w_sgn, w_bz;
  logic        w_neg_a, w_neg_b;
  logic [63:0] w_prod;
  logic [31:0] w_ma, w_mb, w_q, w_r, w_quo, w_rem;
  assign w_busy = (r_state == RUN);
  assign w_md   = ~bus.MDU_Sel[2];
  assign w_div  = bus.MDU_Sel[1];
  assign w_sgn  = ~bus.MDU_Sel[0];
  assign w_acc  = bus.Start & ~bus.Flush & (r_state == IDLE);
  assign w_bz   = (bus.B == 32'd0);
  // One 64-bit multiplier serves both flavours: sign-extending the operands gives the signed product in the low 64 bits
  assign w_prod = {{32{w_sgn & bus.A[31]}}, bus.A} * {{32{w_sgn & bus.B[31]}}, bus.B};
  // Signed division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with remainder 0
  assign w_neg_a = w_sgn & bus.A[31];
  assign w_neg_b = w_sgn & bus.B[31];
  assign w_ma    = w_neg_a ? -bus.A : bus.A;
  assign w_mb    = w_neg_b ? -bus.B : bus.B;
  assign w_q     = w_bz ? 32'd0 : w_ma / w_mb;
  assign w_r     = w_bz ? 32'd0 : w_ma % w_mb;
  assign w_quo   = (w_neg_a ^ w_neg_b) ? -w_q : w_q;
  assign w_rem   = w_neg_a ? -w_r : w_r;
  assign bus.Busy     = w_busy;
  assign bus.Done     = w_busy & (r_cnt == '0);
  assign bus.Stall_MD = Rst & bus.IsMD_D & (w_busy | (bus.Start & ~bus.Flush & w_md));
  assign bus.HI       = r_hi;
  assign bus.LO       = r_lo;
  // Next state: accept in IDLE, count down in RUN, commit pending result on the last busy cycle
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_hi_n    = r_hi;
    w_lo_n    = r_lo;
    w_hi_p_n  = r_hi_p;
    w_lo_p_n  = r_lo_p;
    if (r_state == RUN) begin
      if (r_cnt == '0) begin
        w_state_n = IDLE;
        w_hi_n    = r_hi_p;
        w_lo_n    = r_lo_p;
      end else begin
        w_cnt_n = r_cnt - CW'(1);
      end
    end else if (w_acc && w_md) begin
      w_state_n = RUN;
      w_cnt_n   = w_div ? CW'(DIV_CYC - 1) : CW'(MULT_CYC - 1);
      w_hi_p_n  = w_div ? (w_bz ? r_hi : w_rem) : w_prod[63:32];
      w_lo_p_n  = w_div ? (w_bz ? r_lo : w_quo) : w_prod[31:0];
    end else if (w_acc && bus.MDU_Sel[2:1] == 2'b10) begin
      w_hi_n = bus.MDU_Sel[0] ? r_hi : bus.A;
      w_lo_n = bus.MDU_Sel[0] ? bus.A : r_lo;
    end
  end
  // State, counter, architectural and pending HI/LO registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_hi_p  <= '0;
      r_lo_p  <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_hi    <= w_hi_n;
      r_lo    <= w_lo_n;
      r_hi_p  <= w_hi_p_n;
      r_lo_p  <= w_lo_p_n;
    end
  end
endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: vector table, corner sequences and random ops against an arithmetic HI/LO model
module tb_mdu_sched;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  mdu_sched_if bus();
  mdu_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (.Clk(clk), .Rst(rst_n), .bus(bus));
  int n_pass = 0;
  int n_tot  = 0;
  logic [31:0] mhi, mlo;
  int mn;
  int r_n, r_dp, r_sc;
  logic r_st0, r_sa;
  typedef struct {
    logic [2:0]  sel;
    logic [31:0] a, b, hi, lo;
    int          n;
  } vec_t;
  vec_t tbl[8];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic model(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b, input logic fl);
    longint p;
    logic [63:0] u;
    mn = 0;
    if (fl) return;
    case (sel)
      3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); {mhi, mlo} = p; mn = 5; end
      3'd1: begin u = {32'b0, a} * {32'b0, b}; {mhi, mlo} = u; mn = 5; end
      3'd2: begin
        mn = 10;
        if (b != 0) begin
          p = longint'($signed(a)) / longint'($signed(b)); mlo = p[31:0];
          p = longint'($signed(a)) % longint'($signed(b)); mhi = p[31:0];
        end
      end
      3'd3: begin
        mn = 10;
        if (b != 0) begin
          u = {32'b0, a} / {32'b0, b}; mlo = u[31:0];
          u = {32'b0, a} % {32'b0, b}; mhi = u[31:0];
        end
      end
      3'd4: mhi = a;
      3'd5: mlo = a;
      default: ;
    endcase
  endtask
  task automatic run(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                     input logic fl, input logic md, input int fl_at, input int st_at);
    bus.Start = 1'b1; bus.MDU_Sel = sel; bus.A = a; bus.B = b; bus.Flush = fl; bus.IsMD_D = md;
    #1 r_st0 = bus.Stall_MD;
    @(posedge clk);
    #1 bus.Start = 1'b0; bus.Flush = 1'b0;
    r_n = 0; r_dp = -1; r_sc = 0;
    @(negedge clk);
    while (bus.Busy && r_n < 40) begin
      if (bus.Done) r_dp = r_n;
      if (bus.Stall_MD) r_sc++;
      bus.Flush = (r_n == fl_at);
      bus.Start = (r_n == st_at);
      if (r_n == st_at) begin bus.MDU_Sel = 3'd4; bus.A = 32'hDEADBEEF; end
      r_n++;
      @(negedge clk);
    end
    bus.Start = 1'b0; bus.Flush = 1'b0;
    #1 r_sa = bus.Stall_MD;
  endtask
  task automatic chk_op(input string tag, input logic md, input logic st0,
                        input logic [31:0] hi, input logic [31:0] lo, input int n);
    check({tag, " busy_len"}, r_n, n);
    check({tag, " done_pos"}, r_dp, n - 1);
    check({tag, " stall_t"}, r_st0, st0);
    check({tag, " stall_cnt"}, r_sc, md ? n : 0);
    check({tag, " stall_after"}, r_sa, 0);
    check({tag, " hi"}, bus.HI, hi);
    check({tag, " lo"}, bus.LO, lo);
  endtask
  initial begin
    logic [2:0] sel;
    logic [31:0] a, b;
    logic fl, md;
    tbl[0] = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    tbl[1] = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, 5};
    tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[3] = '{3'd3, 32'd7,        32'd2,        32'd1,        32'd3,        10};
    tbl[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10};
    tbl[5] = '{3'd4, 32'h12345678, 32'd9,        32'h12345678, 32'h80000000, 0};
    tbl[6] = '{3'd5, 32'hCAFE0000, 32'd9,        32'h12345678, 32'hCAFE0000, 0};
    tbl[7] = '{3'd7, 32'hFFFFFFFF, 32'd1,        32'h12345678, 32'hCAFE0000, 0};
    rst_n = 1'b1;
    bus.Start = 1'b0; bus.MDU_Sel = 3'd0; bus.A = '0; bus.B = '0; bus.IsMD_D = 1'b0; bus.Flush = 1'b0;
    #2 rst_n = 1'b0;
    bus.Start = 1'b1; bus.IsMD_D = 1'b1; bus.A = 32'd5; bus.B = 32'd6;
    repeat (2) @(negedge clk);
    check("rst busy", bus.Busy, 0);
    check("rst done", bus.Done, 0);
    check("rst stall", bus.Stall_MD, 0);
    check("rst hi", bus.HI, 0);
    check("rst lo", bus.LO, 0);
    bus.Start = 1'b0; bus.IsMD_D = 1'b0; rst_n = 1'b1;
    mhi = '0; mlo = '0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      model(tbl[i].sel, tbl[i].a, tbl[i].b, 1'b0);
      run(tbl[i].sel, tbl[i].a, tbl[i].b, 1'b0, 1'b1, -1, -1);
      chk_op($sformatf("vec%0d", i), 1'b1, tbl[i].n > 0, tbl[i].hi, tbl[i].lo, tbl[i].n);
    end
    model(3'd5, 32'h11111111, 32'd0, 1'b1);
    run(3'd5, 32'h11111111, 32'd0, 1'b1, 1'b1, -1, -1);
    chk_op("mtlo_flush", 1'b1, 1'b0, 32'h12345678, 32'hCAFE0000, 0);
    model(3'd0, 32'd7, 32'd9, 1'b1);
    run(3'd0, 32'd7, 32'd9, 1'b1, 1'b1, -1, -1);
    chk_op("mult_flush", 1'b1, 1'b0, 32'h12345678, 32'hCAFE0000, 0);
    model(3'd0, 32'h10000, 32'h10000, 1'b0);
    run(3'd0, 32'h10000, 32'h10000, 1'b0, 1'b0, -1, -1);
    chk_op("mult_nostall", 1'b0, 1'b0, 32'h1, 32'h0, 5);
    model(3'd2, 32'd100, 32'hFFFFFFF9, 1'b0);
    run(3'd2, 32'd100, 32'hFFFFFFF9, 1'b0, 1'b1, 2, -1);
    chk_op("div_flush_mid", 1'b1, 1'b1, 32'h2, 32'hFFFFFFF2, 10);
    model(3'd4, 32'hAA, 32'd0, 1'b0);
    run(3'd4, 32'hAA, 32'd0, 1'b0, 1'b0, -1, -1);
    model(3'd5, 32'hBB, 32'd0, 1'b0);
    run(3'd5, 32'hBB, 32'd0, 1'b0, 1'b0, -1, -1);
    model(3'd2, 32'd5, 32'd0, 1'b0);
    run(3'd2, 32'd5, 32'd0, 1'b0, 1'b1, -1, -1);
    chk_op("div_zero", 1'b1, 1'b1, 32'hAA, 32'hBB, 10);
    model(3'd0, 32'd6, 32'd7, 1'b0);
    run(3'd0, 32'd6, 32'd7, 1'b0, 1'b1, -1, 2);
    chk_op("start_in_run", 1'b1, 1'b1, 32'h0, 32'd42, 5);
    bus.Start = 1'b1; bus.MDU_Sel = 3'd0; bus.A = 32'd3; bus.B = 32'd4; bus.IsMD_D = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", bus.Busy, 0);
    check("midrst done", bus.Done, 0);
    check("midrst stall", bus.Stall_MD, 0);
    check("midrst hi", bus.HI, 0);
    check("midrst lo", bus.LO, 0);
    @(negedge clk);
    rst_n = 1'b1; bus.IsMD_D = 1'b0;
    mhi = '0; mlo = '0;
    model(3'd0, 32'd3, 32'd4, 1'b0);
    run(3'd0, 32'd3, 32'd4, 1'b0, 1'b1, -1, -1);
    chk_op("after_reset", 1'b1, 1'b1, 32'h0, 32'd12, 5);
    for (int i = 0; i < 40; i++) begin
      sel = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      fl  = ($urandom_range(0, 5) == 0);
      md  = 1'($urandom_range(0, 1));
      model(sel, a, b, fl);
      run(sel, a, b, fl, md, -1, -1);
      chk_op($sformatf("rnd%0d", i), md, md & ~fl & ~sel[2], mhi, mlo, mn);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
